microsequencer: RTL

Microprogram sequencer for the microcoded control unit. Drives the address of the asynchronous microcode ROM and reads back the 29-bit microword. Exports bits [28:7] as datapath control and decodes bits [6:0] to pick the next micro-address. Handles dispatch on the instruction opcode, flag-conditioned continuation, memory wait stalls, halt/resume and instruction counting.

---
 rtl/microseq_pkg.sv | 33 +++
 rtl/microseq_cond.sv | 24 ++
 rtl/microsequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogram sequencer: sequencing ops, condition
// codes, microword field positions and the sequencer state type.
package microseq_pkg;

  localparam logic [2:0] OP_NEXT     = 3'b000;
  localparam logic [2:0] OP_END      = 3'b001;
  localparam logic [2:0] OP_CSKIP    = 3'b010;
  localparam logic [2:0] OP_RSV3     = 3'b011;
  localparam logic [2:0] OP_HALT     = 3'b100;
  localparam logic [2:0] OP_DISPATCH = 3'b101;
  localparam logic [2:0] OP_RSV6     = 3'b110;
  localparam logic [2:0] OP_RSV7     = 3'b111;

  localparam logic [3:0] COND_TRUE = 4'b0001;
  localparam logic [3:0] COND_Z    = 4'b0010;
  localparam logic [3:0] COND_N    = 4'b0011;
  localparam logic [3:0] COND_C    = 4'b0100;
  localparam logic [3:0] COND_NZ   = 4'b0101;

  localparam int unsigned CTRL_MSB = 28;
  localparam int unsigned CTRL_LSB = 7;
  localparam int unsigned COND_MSB = 6;
  localparam int unsigned COND_LSB = 3;
  localparam int unsigned OP_MSB   = 2;
  localparam int unsigned OP_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/microseq_cond.sv
// Condition-code select over the ALU flags; unlisted codes evaluate false.
module microseq_cond
  import microseq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_TRUE: cond_true = 1'b1;
      COND_Z:    cond_true = flag_z;
      COND_N:    cond_true = flag_n;
      COND_C:    cond_true = flag_c;
      COND_NZ:   cond_true = ~flag_z;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: drives the microcode ROM address, exports the control
// field and decodes the sequencing field into the next micro-address.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 29,
  parameter int OPC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              resume,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_c,
  input  logic              mem_wait,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [WORD_W-1:0] r_data,
  output logic [WORD_W-8:0] ctrl,
  output logic              step_en,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_count,
  output logic              halted,
  output logic              illegal
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] upc, upc_nxt;
  logic [2:0]        op;
  logic [3:0]        cond;
  logic              cond_true;
  logic              retire;
  logic              set_ill;
  logic              slot_end;
  logic              zero_word;

  assign op        = r_data[OP_MSB:OP_LSB];
  assign cond      = r_data[COND_MSB:COND_LSB];
  assign slot_end  = (upc[2:0] == 3'b111);
  assign zero_word = (r_data == '0);

  microseq_cond u_cond (
    .cond      (cond),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .cond_true (cond_true)
  );

  always_comb begin
    state_nxt = state;
    upc_nxt   = upc;
    retire    = 1'b0;
    set_ill   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          upc_nxt   = '0;
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt = RUN;
          upc_nxt   = '0;
        end
      end
      RUN: begin
        if (!mem_wait) begin
          case (op)
            OP_NEXT, OP_RSV3, OP_RSV6, OP_RSV7: begin
              set_ill = (op != OP_NEXT);
              // falling off the end of an 8-word slot, or a blank word, retires
              if (slot_end || zero_word) begin
                upc_nxt = '0;
                retire  = 1'b1;
              end else begin
                upc_nxt = upc + ADDR_W'(1);
              end
            end
            OP_END: begin
              upc_nxt = '0;
              retire  = 1'b1;
            end
            OP_CSKIP: begin
              if (cond_true) begin
                upc_nxt = upc + ADDR_W'(1);
              end else begin
                upc_nxt = '0;
                retire  = 1'b1;
              end
            end
            OP_DISPATCH: upc_nxt = ADDR_W'({opcode, 3'b000});
            OP_HALT: begin
              upc_nxt   = '0;
              state_nxt = HALT;
            end
            default: upc_nxt = upc;
          endcase
        end
      end
      default: begin
        state_nxt = IDLE;
        upc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      upc         <= '0;
      instr_done  <= 1'b0;
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      state      <= state_nxt;
      upc        <= upc_nxt;
      instr_done <= retire;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (set_ill) illegal <= 1'b1;
    end
  end

  assign r_addr  = upc;
  assign step_en = (state == RUN) && !mem_wait;
  assign ctrl    = (state == RUN) ? r_data[CTRL_MSB:CTRL_LSB] : '0;
  assign halted  = (state == HALT);

endmodule
